// File: rtl/onion_timer_pkg.sv
// Shared types and constants for the multi-channel timer.
// Channel state encoding and mode bit meanings live here so every file agrees.
package onion_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/onion_timer_mc_if.sv
// Configuration and status bundle between a host and the multi-channel timer.
interface onion_timer_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
);
    logic [PRE_W-1:0]        prescale;
    logic [NUM_CH*CNT_W-1:0] period;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH-1:0]       irq_en;
    logic [NUM_CH-1:0]       alarm_o;
    logic [NUM_CH-1:0]       pulse_o;
    logic                    irq_o;

    modport master (
        output prescale, period, mode, enable, clear, irq_en,
        input  alarm_o, pulse_o, irq_o
    );

    modport slave (
        input  prescale, period, mode, enable, clear, irq_en,
        output alarm_o, pulse_o, irq_o
    );
endinterface

// File: rtl/onion_timer_ch.sv
// One timer channel: IDLE/RUN/DONE state machine, tick counter,
// sticky alarm and a registered one-clock expiry pulse.
module onion_timer_ch
    import onion_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] period,
    input  logic             mode,
    input  logic             enable,
    input  logic             clear,
    output logic             alarm,
    output logic             pulse
);

    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             alarm_reg, alarm_next;
    logic             pulse_reg, pulse_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            alarm_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            alarm_reg <= alarm_next;
            pulse_reg <= pulse_next;
        end
    end

    // Priority: enable low, then clear, then expiry/count.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        alarm_next = alarm_reg;
        pulse_next = 1'b0;

        if (!enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            alarm_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                    alarm_next = 1'b0;
                end
                ST_RUN: begin
                    if (clear) begin
                        cnt_next   = '0;
                        alarm_next = 1'b0;
                    end else if (tick) begin
                        // >= so a period lowered below cnt expires on the next tick
                        if (cnt_reg >= period) begin
                            pulse_next = 1'b1;
                            alarm_next = 1'b1;
                            if (mode == MODE_PERIODIC) begin
                                cnt_next = '0;
                            end else begin
                                state_next = ST_DONE;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                        alarm_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    alarm_next = 1'b0;
                end
            endcase
        end
    end

    assign alarm = alarm_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/onion_timer_mc.sv
// Multi-channel timer: one shared prescaler feeding NUM_CH independent
// channels, with a masked OR of the channel alarms as the interrupt.
module onion_timer_mc
    import onion_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    onion_timer_mc_if.slave  bus
);

    logic [PRE_W-1:0]  pre_ctr_reg, pre_ctr_next;
    logic              tick;
    logic [NUM_CH-1:0] alarm;
    logic [NUM_CH-1:0] pulse;

    // >= keeps latency bounded if prescale is lowered below the running count.
    assign tick = (pre_ctr_reg >= bus.prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_ctr_reg <= '0;
        end else begin
            pre_ctr_reg <= pre_ctr_next;
        end
    end

    always_comb begin
        pre_ctr_next = pre_ctr_reg + PRE_W'(1);
        if (!(|bus.enable) || tick) begin
            pre_ctr_next = '0;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        onion_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .period (bus.period[gi*CNT_W +: CNT_W]),
            .mode   (bus.mode[gi]),
            .enable (bus.enable[gi]),
            .clear  (bus.clear[gi]),
            .alarm  (alarm[gi]),
            .pulse  (pulse[gi])
        );
    end

    assign bus.alarm_o = alarm;
    assign bus.pulse_o = pulse;
    assign bus.irq_o   = |(alarm & bus.irq_en);

endmodule

// File: tb/tb_onion_timer_mc.sv
// Scoreboarded bench for onion_timer_mc: expected pulse cycles are queued
// when stimulus is driven and matched against pulses seen at the falling edge.
module tb_onion_timer_mc;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int PRE_W  = 8;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_miss;
    int   exp_q[$];

    onion_timer_mc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus();

    onion_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse keys encode cycle*16 + channel; pushes must be in time/channel order.
    task automatic expect_pulse(input int at, input int ch);
        exp_q.push_back(at * 16 + ch);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int ch, input int val);
        bus.period[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    always @(negedge clk) begin
        int e;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.pulse_o[ch]) begin
                $display("cyc %0d: pulse on ch%0d", cyc, ch);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("pulse_at", cyc * 16 + ch, e);
                end else begin
                    check_eq("spurious_pulse", cyc * 16 + ch, -1);
                end
            end
        end
        while (exp_q.size() > 0 && (exp_q[0] / 16) <= cyc) begin
            e = exp_q.pop_front();
            check_eq("missed_pulse", -1, e);
        end
    end

    initial begin
        int c;
        int c2;
        n_vec  = 0;
        n_miss = 0;

        // Reset held with random inputs
        reset = 1'b0;
        bus.prescale = PRE_W'($urandom);
        bus.period   = {$urandom, $urandom, $urandom, $urandom};
        bus.mode     = NUM_CH'($urandom);
        bus.enable   = NUM_CH'($urandom);
        bus.clear    = NUM_CH'($urandom);
        bus.irq_en   = NUM_CH'($urandom);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_eq("rst_alarm", int'(bus.alarm_o), 0);
            check_eq("rst_pulse", int'(bus.pulse_o), 0);
            check_eq("rst_irq", int'(bus.irq_o), 0);
            bus.enable = NUM_CH'($urandom);
            bus.clear  = NUM_CH'($urandom);
            bus.irq_en = NUM_CH'($urandom);
        end
        bus.prescale = '0;
        bus.period   = '0;
        bus.mode     = '0;
        bus.enable   = '0;
        bus.clear    = '0;
        bus.irq_en   = '0;
        step(1);
        reset = 1'b1;
        step(3);
        check_eq("idle_alarm", int'(bus.alarm_o), 0);
        check_eq("idle_irq", int'(bus.irq_o), 0);

        // One-shot on ch0, P=5: pulse at drive cycle + 7
        set_period(0, 5);
        bus.mode[0] = 1'b0;
        c = cyc;
        bus.enable[0] = 1'b1;
        expect_pulse(c + 7, 0);
        step(10);
        check_eq("os_alarm", int'(bus.alarm_o[0]), 1);
        step(50);
        check_eq("os_alarm_sticky", int'(bus.alarm_o[0]), 1);
        c2 = cyc;
        bus.clear[0] = 1'b1;
        step(1);
        bus.clear[0] = 1'b0;
        check_eq("os_clear_alarm", int'(bus.alarm_o[0]), 0);
        expect_pulse(c2 + 7, 0);
        step(9);
        check_eq("os_rearm_alarm", int'(bus.alarm_o[0]), 1);
        check_eq("os_q_empty", exp_q.size(), 0);
        bus.enable[0] = 1'b0;
        step(2);

        // Periodic ch1, prescale=3, P=2: first at +12 (prescaler starts at 0), then every 12
        bus.prescale = 8'd3;
        set_period(1, 2);
        bus.mode[1] = 1'b1;
        c = cyc;
        bus.enable[1] = 1'b1;
        for (int k = 0; k < 5; k++) expect_pulse(c + 12 + 12 * k, 1);
        step(13);
        check_eq("per_alarm", int'(bus.alarm_o[1]), 1);
        check_eq("per_irq_masked", int'(bus.irq_o), 0);
        bus.irq_en[1] = 1'b1;
        #1;
        check_eq("per_irq_on", int'(bus.irq_o), 1);
        step(49);
        bus.enable[1] = 1'b0;
        step(1);
        check_eq("per_dis_alarm", int'(bus.alarm_o[1]), 0);
        check_eq("per_dis_irq", int'(bus.irq_o), 0);
        check_eq("per_q_empty", exp_q.size(), 0);
        bus.irq_en   = '0;
        bus.prescale = '0;
        step(2);

        // period=0 periodic on ch2: pulse every cycle after the first
        set_period(2, 0);
        bus.mode[2] = 1'b1;
        c = cyc;
        bus.enable[2] = 1'b1;
        for (int k = 2; k <= 20; k++) expect_pulse(c + k, 2);
        step(20);
        bus.enable[2] = 1'b0;
        step(2);

        // Period lowered 100 -> 3 at cnt=50 on ch3: expiry on the next tick
        set_period(3, 100);
        bus.mode[3] = 1'b1;
        c = cyc;
        bus.enable[3] = 1'b1;
        step(51);
        set_period(3, 3);
        expect_pulse(c + 52, 3);
        expect_pulse(c + 56, 3);
        step(7);
        bus.enable[3] = 1'b0;
        step(2);

        // clear on ch2 in the exact expiry cycle suppresses the pulse and restarts
        set_period(2, 4);
        bus.mode[2] = 1'b1;
        c = cyc;
        bus.enable[2] = 1'b1;
        step(5);
        bus.clear[2] = 1'b1;
        step(1);
        bus.clear[2] = 1'b0;
        check_eq("clr_exp_alarm", int'(bus.alarm_o[2]), 0);
        check_eq("clr_exp_pulse", int'(bus.pulse_o[2]), 0);
        expect_pulse(c + 11, 2);
        step(6);
        check_eq("clr_restart_alarm", int'(bus.alarm_o[2]), 1);
        bus.enable[2] = 1'b0;
        step(2);

        // Simultaneous expiry on ch0 and ch3
        set_period(0, 3);
        bus.mode[0] = 1'b0;
        set_period(3, 3);
        bus.mode[3] = 1'b1;
        c = cyc;
        bus.enable = 4'b1001;
        expect_pulse(c + 5, 0);
        expect_pulse(c + 5, 3);
        step(7);
        check_eq("sim_alarm", int'(bus.alarm_o), 9);
        bus.enable = '0;
        step(2);

        // Enable dropped at cnt=3 and restored: full latency again
        set_period(0, 5);
        bus.mode[0] = 1'b0;
        c = cyc;
        bus.enable[0] = 1'b1;
        step(4);
        bus.enable[0] = 1'b0;
        step(1);
        bus.enable[0] = 1'b1;
        expect_pulse(c + 12, 0);
        step(9);
        check_eq("reen_alarm", int'(bus.alarm_o[0]), 1);
        bus.enable[0] = 1'b0;
        step(2);

        // Asynchronous reset mid-run
        set_period(1, 10);
        bus.mode[1]   = 1'b1;
        bus.irq_en[1] = 1'b1;
        c = cyc;
        bus.enable[1] = 1'b1;
        expect_pulse(c + 12, 1);
        step(14);
        check_eq("pre_rst_irq", int'(bus.irq_o), 1);
        reset = 1'b0;
        #1;
        check_eq("async_alarm", int'(bus.alarm_o), 0);
        check_eq("async_pulse", int'(bus.pulse_o), 0);
        check_eq("async_irq", int'(bus.irq_o), 0);
        step(2);
        bus.enable = '0;
        bus.irq_en = '0;
        reset = 1'b1;
        step(3);
        check_eq("final_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
